seq_alu: RTL and testbench

- WIDTH-bit successor to the team's 2-bit-opcode, 1-bit ALU.
- Keeps the ADD/SUB/OR/AND encodings with carry/borrow on a side output.
- Adds XOR, a multi-cycle shift-add multiply, status flags and valid/ready handshakes on both sides.
- Sits between an operand-issuing controller and a result consumer that may stall.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 130 +++++++++++++
 tb/tb_seq_alu.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: a valid/ready request
// channel carrying op and operands, and a valid/ready response channel carrying result and flags.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             overflow;

  // Controller/consumer side drives requests and takes results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, overflow
  );

  // ALU side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// WIDTH-bit sequential ALU: single-cycle ADD/SUB/OR/AND/XOR, shift-add MUL
// over WIDTH cycles, registered result and flags held until the consumer takes them.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q, zero_q, overflow_q;

  logic               accept, mul_last;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

  assign accept   = bus.in_valid && (state == IDLE);
  assign mul_last = (state == MUL) && (count == CW'(WIDTH - 1));
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (bus.op == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops; reserved encodings fall through to all-zero.
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (bus.a < bus.b);
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      default: alu_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (bus.op == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
          end else begin
            result_q   <= alu_res;
            carry_q    <= alu_c;
            overflow_q <= alu_v;
            zero_q     <= (alu_res == '0);
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (mul_last) begin
            result_q   <= acc_next[WIDTH-1:0];
            carry_q    <= |acc_next[2*WIDTH-1:WIDTH];
            overflow_q <= 1'b0;
            zero_q     <= (acc_next[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): hand-computed vectors covering each op,
// flag corner cases, multiply latency, output backpressure and mid-operation reset.
module tb_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op; returns #1 after the accepting edge with operands scrambled.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.a  = 8'($urandom);
    bus.b  = 8'($urandom);
  endtask

  // Waits (bounded) for out_valid, checks edges waited and the result/flags,
  // then lets the handshake complete with out_ready high.
  task automatic expect_out(input string tag, input int edges, input logic [7:0] res,
                            input logic c, input logic z, input logic v);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 16'(n), 16'(edges));
    check({tag, "_res"}, 16'(bus.result), 16'(res));
    check({tag, "_c"}, 16'(bus.carry), 16'(c));
    check({tag, "_z"}, 16'(bus.zero), 16'(z));
    check({tag, "_v"}, 16'(bus.overflow), 16'(v));
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_drop"}, 16'(bus.out_valid), 16'(0));
    check({tag, "_rdy"}, 16'(bus.in_ready), 16'(1));
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check("rst_in_ready", 16'(bus.in_ready), 16'(1));
    check("rst_out_valid", 16'(bus.out_valid), 16'(0));
    check("rst_result", 16'(bus.result), 16'(0));
    check("rst_flags", {13'b0, bus.carry, bus.zero, bus.overflow}, 16'(0));
    rst = 1'b0;
    tick();

    issue(3'b000, 8'd200, 8'd100);
    expect_out("add_200_100", 0, 8'd44, 1'b1, 1'b0, 1'b0);
    issue(3'b000, 8'h7F, 8'h01);
    expect_out("add_ovf", 0, 8'h80, 1'b0, 1'b0, 1'b1);
    issue(3'b001, 8'd5, 8'd7);
    expect_out("sub_5_7", 0, 8'hFE, 1'b1, 1'b0, 1'b0);
    issue(3'b001, 8'd9, 8'd9);
    expect_out("sub_9_9", 0, 8'h00, 1'b0, 1'b1, 1'b0);
    issue(3'b001, 8'h80, 8'h01);
    expect_out("sub_ovf", 0, 8'h7F, 1'b0, 1'b0, 1'b1);
    issue(3'b011, 8'hC3, 8'h5A);
    expect_out("and", 0, 8'h42, 1'b0, 1'b0, 1'b0);

    issue(3'b101, 8'd13, 8'd11);
    check("mul_busy", 16'(bus.in_ready), 16'(0));
    expect_out("mul_13_11", 8, 8'h8F, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 8'd16, 8'd16);
    expect_out("mul_16_16", 8, 8'h00, 1'b1, 1'b1, 1'b0);
    issue(3'b101, 8'd255, 8'd255);
    expect_out("mul_255_255", 8, 8'h01, 1'b1, 1'b0, 1'b0);

    // Backpressure with a competing request during the stall.
    bus.out_ready = 1'b0;
    issue(3'b010, 8'hA5, 8'h0F);
    bus.in_valid = 1'b1;
    bus.op = 3'b000;
    bus.a = 8'h01;
    bus.b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 16'(bus.out_valid), 16'(1));
      check("bp_result", 16'(bus.result), 16'hAF);
      check("bp_in_ready", 16'(bus.in_ready), 16'(0));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_drop", 16'(bus.out_valid), 16'(0));
    check("bp_no_accept", 16'(bus.result), 16'hAF);
    tick();
    check("bp_idle", 16'(bus.out_valid), 16'(0));

    // Reset during MUL cycle 4.
    issue(3'b101, 8'd255, 8'd255);
    tick();
    tick();
    tick();
    check("mid_busy", 16'(bus.in_ready), 16'(0));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 16'(bus.out_valid), 16'(0));
    check("mid_rst_ready", 16'(bus.in_ready), 16'(1));
    check("mid_rst_result", 16'(bus.result), 16'(0));
    check("mid_rst_flags", {13'b0, bus.carry, bus.zero, bus.overflow}, 16'(0));
    tick();
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.out_valid) pulses++;
      end
      check("mid_no_pulse", 16'(pulses), 16'(0));
    end
    issue(3'b100, 8'hF0, 8'hFF);
    expect_out("xor_after_rst", 0, 8'h0F, 1'b0, 1'b0, 1'b0);

    issue(3'b111, 8'hFF, 8'hFF);
    expect_out("reserved_111", 0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
